display_arbiter: RTL and testbench

//  Shares the single 4-digit seven-segment display among NREQ requesters (register

---
 rtl/display_arbiter.sv | 135 +++++++++++++
 tb/tb_display_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/display_arbiter.sv
// display_arbiter: round-robin owner of the shared 4-digit hex display.
// Each grant is held for HOLD_CYCLES clocks so the value stays readable.
module display_arbiter #(
    parameter int          NREQ        = 4,
    parameter int          HOLD_CYCLES = 50000000,
    parameter logic [15:0] IDLE_VALUE  = 16'h0000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [16*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]      gnt,
    output logic [2:0]           owner,
    output logic [15:0]          disp_data,
    output logic                 busy
);
    localparam int PW = $clog2(NREQ);
    localparam int CL = $clog2(HOLD_CYCLES);
    localparam int CW = (CL < 1) ? 1 : CL;
    localparam logic [CW-1:0] RELOAD = CW'(HOLD_CYCLES - 1);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic [PW-1:0]     ptr, ptr_nxt, win, win_inc;
    logic [NREQ-1:0]   cand, gnt_nxt;
    logic [2*NREQ-1:0] dbl;
    logic [PW:0]       off, sum;
    logic [2:0]        owner_nxt;
    logic [15:0]       disp_nxt, own_data, win_data;
    logic              found, own_req, expired;

    // The current owner is never a candidate; in IDLE gnt is zero.
    assign cand    = req & ~gnt;
    assign own_req = |(req & gnt);
    assign expired = (cnt == '0);
    assign busy    = (state == HOLD);
    assign win_inc = (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;

    // Rotate candidates so the pointer sits at bit 0, take the lowest set bit.
    always_comb begin
        found = 1'b0;
        off   = '0;
        dbl   = {cand, cand} >> ptr;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (dbl[k]) begin
                found = 1'b1;
                off   = (PW+1)'(k);
            end
        end
        sum = {1'b0, ptr} + off;
        if (sum >= (PW+1)'(NREQ))
            win = PW'(sum - (PW+1)'(NREQ));
        else
            win = PW'(sum);
    end

    // Only the selected slice is ever looked at.
    always_comb begin
        own_data = IDLE_VALUE;
        win_data = IDLE_VALUE;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i])
                own_data = req_data[16*i +: 16];
            if (win == PW'(i))
                win_data = req_data[16*i +: 16];
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (found) state_nxt = HOLD;
            HOLD: if (expired && !found && !own_req)
                      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        gnt_nxt   = gnt;
        owner_nxt = owner;
        ptr_nxt   = ptr;
        cnt_nxt   = cnt;
        disp_nxt  = disp_data;
        unique case (state)
            IDLE: begin
                if (found) begin
                    gnt_nxt   = NREQ'(1) << win;
                    owner_nxt = 3'(win);
                    ptr_nxt   = win_inc;
                    cnt_nxt   = RELOAD;
                end
            end
            HOLD: begin
                if (own_req)
                    disp_nxt = own_data;
                if (!expired) begin
                    cnt_nxt = cnt - 1'b1;
                end else if (found) begin
                    gnt_nxt   = NREQ'(1) << win;
                    owner_nxt = 3'(win);
                    ptr_nxt   = win_inc;
                    cnt_nxt   = RELOAD;
                    disp_nxt  = win_data;
                end else if (own_req) begin
                    cnt_nxt = RELOAD;
                end else begin
                    gnt_nxt  = '0;
                    disp_nxt = IDLE_VALUE;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            gnt       <= '0;
            owner     <= '0;
            ptr       <= '0;
            cnt       <= '0;
            disp_data <= IDLE_VALUE;
        end else begin
            state     <= state_nxt;
            gnt       <= gnt_nxt;
            owner     <= owner_nxt;
            ptr       <= ptr_nxt;
            cnt       <= cnt_nxt;
            disp_data <= disp_nxt;
        end
    end
endmodule

// File: tb/tb_display_arbiter.sv
// tb_display_arbiter: directed and random stimulus against a
// grant-age model of the display arbiter (hold 4 and hold 1 builds).
module tb_display_arbiter;
    logic        clk = 1'b0;
    logic        reset, rst1;
    logic [3:0]  req, req1;
    logic [63:0] data, data1;
    logic [3:0]  gnt, gnt1;
    logic [2:0]  owner, owner1;
    logic [15:0] disp, disp1;
    logic        busy, busy1;
    int          n_chk = 0;
    int          n_fail = 0;
    int          rot[4] = '{0, 1, 3, 0};
    int          o;

    always #5 clk = ~clk;

    display_arbiter #(
        .NREQ(4), .HOLD_CYCLES(4), .IDLE_VALUE(16'h0000)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .req_data(data),
        .gnt(gnt), .owner(owner), .disp_data(disp), .busy(busy)
    );

    display_arbiter #(
        .NREQ(4), .HOLD_CYCLES(1), .IDLE_VALUE(16'h0000)
    ) dut1 (
        .clk(clk), .reset(rst1), .req(req1), .req_data(data1),
        .gnt(gnt1), .owner(owner1), .disp_data(disp1), .busy(busy1)
    );

    // shown = clocks the current grant has been visible so far
    typedef struct packed {
        logic        active;
        int          owner;
        int          ptr;
        int          shown;
        logic [15:0] disp;
    } mdl_t;

    mdl_t m, m1;

    function automatic int pick(logic [3:0] r, int from, int skip);
        for (int k = 0; k < 4; k++) begin
            int i = (from + k) % 4;
            if (r[i] && i != skip) return i;
        end
        return -1;
    endfunction

    function automatic mdl_t step(mdl_t s, logic [3:0] r,
                                  logic [63:0] d, int h);
        mdl_t n = s;
        int   w;
        if (!s.active) begin
            if (r != 4'b0) begin
                w = pick(r, s.ptr, -1);
                n.active = 1'b1;
                n.owner  = w;
                n.ptr    = (w + 1) % 4;
                n.shown  = 1;
            end
        end else begin
            if (r[s.owner]) n.disp = d[16*s.owner +: 16];
            if (s.shown < h) begin
                n.shown = s.shown + 1;
            end else begin
                w = pick(r, s.ptr, s.owner);
                if (w >= 0) begin
                    n.owner = w;
                    n.ptr   = (w + 1) % 4;
                    n.shown = 1;
                    n.disp  = d[16*w +: 16];
                end else if (r[s.owner]) begin
                    n.shown = 1;
                end else begin
                    n.active = 1'b0;
                    n.disp   = 16'h0000;
                end
            end
        end
        return n;
    endfunction

    function automatic logic [3:0] egnt(mdl_t s);
        return s.active ? 4'(1 << s.owner) : 4'b0;
    endfunction

    always @(posedge clk or posedge reset)
        if (reset) m <= '0;
        else m <= step(m, req, data, 4);

    always @(posedge clk or posedge rst1)
        if (rst1) m1 <= '0;
        else m1 <= step(m1, req1, data1, 1);

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("m_gnt", 32'(gnt), 32'(egnt(m)));
        chk("m_owner", 32'(owner), 32'(m.owner));
        chk("m_busy", 32'(busy), 32'(m.active));
        chk("m_disp", 32'(disp), 32'(m.disp));
        chk("m1_gnt", 32'(gnt1), 32'(egnt(m1)));
        chk("m1_owner", 32'(owner1), 32'(m1.owner));
        chk("m1_busy", 32'(busy1), 32'(m1.active));
        chk("m1_disp", 32'(disp1), 32'(m1.disp));
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; rst1 = 1'b1;
        req = '0; req1 = '0; data = '0; data1 = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0; rst1 = 1'b0;
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_owner", 32'(owner), 32'h0);
        chk("rst_disp", 32'(disp), 32'h0);

        data[47:32] = 16'hBEEF;
        req = 4'b0100;
        nxt();
        chk("t2_gnt", 32'(gnt), 32'h4);
        chk("t2_owner", 32'(owner), 32'h2);
        chk("t2_disp0", 32'(disp), 32'h0);
        nxt();
        chk("t2_disp", 32'(disp), 32'hBEEF);
        for (int k = 0; k < 10; k++) begin
            nxt();
            chk("t2_busy", 32'(busy), 32'h1);
            chk("t2_hold", 32'(gnt), 32'h4);
        end
        data[47:32] = 16'h1234;
        nxt();
        chk("t2_track", 32'(disp), 32'h1234);

        #2 reset = 1'b1;
        #1;
        chk("t1_gnt", 32'(gnt), 32'h0);
        chk("t1_busy", 32'(busy), 32'h0);
        chk("t1_disp", 32'(disp), 32'h0);
        req = '0;
        #1 reset = 1'b0;
        repeat (3) begin
            nxt();
            chk("t1_idle_busy", 32'(busy), 32'h0);
            chk("t1_idle_gnt", 32'(gnt), 32'h0);
        end

        data = {16'hA333, 16'hA222, 16'hA111, 16'hA000};
        req = 4'b1011;
        for (int e = 1; e <= 16; e++) begin
            nxt();
            o = rot[(e - 1) / 4];
            chk("t3_gnt", 32'(gnt), 32'(1 << o));
            if (e >= 2) chk("t3_disp", 32'(disp), 32'(data[16*o +: 16]));
        end
        req = '0;
        nxt();
        chk("t3_idle", 32'(gnt), 32'h0);
        chk("t3_idle_disp", 32'(disp), 32'h0);

        data[31:16] = 16'h5A5A;
        req = 4'b0010;
        nxt();
        chk("t4_gnt", 32'(gnt), 32'h2);
        nxt();
        chk("t4_disp", 32'(disp), 32'h5A5A);
        req = '0;
        data[31:16] = 16'hFFFF;
        repeat (2) begin
            nxt();
            chk("t4_hold", 32'(gnt), 32'h2);
            chk("t4_frozen", 32'(disp), 32'h5A5A);
        end
        nxt();
        chk("t4_gnt_off", 32'(gnt), 32'h0);
        chk("t4_busy_off", 32'(busy), 32'h0);
        chk("t4_disp_idle", 32'(disp), 32'h0);
        chk("t4_owner", 32'(owner), 32'h1);

        data[15:0] = 16'h1111;
        data[63:48] = 16'h3333;
        req = 4'b0001;
        for (int e = 1; e <= 4; e++) begin
            nxt();
            chk("t5_own0", 32'(gnt), 32'h1);
        end
        req = 4'b1001;
        nxt();
        chk("t5_gnt3", 32'(gnt), 32'h8);
        chk("t5_owner3", 32'(owner), 32'h3);
        chk("t5_disp3", 32'(disp), 32'h3333);
        repeat (3) nxt();
        chk("t5_still3", 32'(gnt), 32'h8);
        nxt();
        chk("t5_back0", 32'(gnt), 32'h1);
        req = '0;
        repeat (5) nxt();

        req1 = 4'b1111;
        for (int e = 1; e <= 8; e++) begin
            nxt();
            chk("t6_gnt", 32'(gnt1), 32'(1 << ((e - 1) % 4)));
        end
        req1 = '0;
        nxt();

        for (int c = 0; c < 800; c++) begin
            if (c % 3 == 0) begin
                req = 4'($urandom);
                req1 = 4'($urandom);
            end else if (c % 3 == 1) begin
                req = 4'($urandom & $urandom);
                req1 = 4'($urandom & $urandom);
            end
            data = {$urandom, $urandom};
            data1 = {$urandom, $urandom};
            if ($urandom_range(0, 59) == 0) begin
                #2 reset = 1'b1; rst1 = 1'b1;
                #1 reset = 1'b0; rst1 = 1'b0;
            end
            nxt();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
